// File: rtl/arit_pkg.sv
// arit_pkg: widths and FSM states shared by the shift-add multiplier and the restoring divider.
package arit_pkg;
    localparam int W  = 7;
    localparam int AW = 2 * W;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/paso_shift_add.sv
// paso_shift_add: one combinational shift-add iteration of the multiply-accumulate.
module paso_shift_add #(
    parameter int W  = 7,
    parameter int AW = 2 * W
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] mcand,
    input  logic [W-1:0]  mplier,
    input  logic [AW-1:0] unused_pad_n,
    output logic [AW-1:0] acc_next,
    output logic [AW-1:0] mcand_next,
    output logic [W-1:0]  mplier_next
);
    always_comb begin
        acc_next    = mplier[0] ? acc + mcand : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end
endmodule

// File: rtl/multiplicador_acumulador_7bits.sv
// multiplicador_acumulador_7bits: sequential A = Q*B + R over W fixed iterations,
// with the same start/done handshake as the restoring divider.
module multiplicador_acumulador_7bits #(
    parameter int W  = 7,
    parameter int AW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  Q_in,
    input  logic [W-1:0]  B_in,
    input  logic [W-1:0]  R_in,
    output logic [AW-1:0] A,
    output logic          done,
    output logic          busy
);
    import arit_pkg::*;
    localparam int CW = $clog2(W);
    state_t        state;
    logic [AW-1:0] acc, mcand, acc_next, mcand_next;
    logic [W-1:0]  mplier, mplier_next;
    logic [CW-1:0] cnt;
    paso_shift_add #(.W(W), .AW(AW)) u_paso (
        .acc(acc),
        .mcand(mcand),
        .mplier(mplier),
        .unused_pad_n('0),
        .acc_next(acc_next),
        .mcand_next(mcand_next),
        .mplier_next(mplier_next)
    );
    // start is honoured only outside CALC, so an in-flight operation never restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state != CALC && start) begin
            state  <= CALC;
            acc    <= AW'(R_in);
            mcand  <= AW'(B_in);
            mplier <= Q_in;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            cnt    <= cnt + 1'b1;
            state  <= (cnt == CW'(W - 1)) ? DONE : CALC;
        end
    end
    assign A    = acc;
    assign done = (state == DONE);
    assign busy = (state == CALC);
endmodule

// File: doc/multiplicador_acumulador_7bits.md
# multiplicador_acumulador_7bits

Sequential shift-add multiply-accumulate unit computing A = Q·B + R for 7-bit unsigned operands, producing a 14-bit result. It is the inverse-direction companion of `divisor_restoring_7bits`: it reconstructs the dividend from quotient, divisor and remainder. It sits beside the divider in the arithmetic datapath and uses the same start/done handshake, so a single bench or controller drives both. It also serves as the in-system checker for divider results.

## Interface
Parameters:
- `W`, 7: operand width (Q, B, R).
- `AW`, 2*W = 14: result width. Max result 127·127+127 = 16256 fits in 14 bits, so no overflow is possible.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request. Sampled only in IDLE or DONE.
- `Q_in`  in  W  multiplier (quotient), unsigned.
- `B_in`  in  W  multiplicand (divisor), unsigned.
- `R_in`  in  W  addend (remainder), unsigned.
- `A`  out  AW  result; valid while `done`=1.
- `done`  out  1  result valid. Level, held until the next accepted start or reset.
- `busy`  out  1  high in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with `start`=1, load on the clock edge:
  - acc ← zero-extended `R_in`
  - mcand ← zero-extended `B_in` (AW bits)
  - mplier ← `Q_in`
  - cnt ← 0
  - next state: CALC.
- CALC, once per cycle:
  - if mplier[0], acc ← acc + mcand
  - mcand ← mcand << 1
  - mplier ← mplier >> 1
  - cnt ← cnt + 1
  - after W iterations (cnt reaches W-1 this cycle), next state: DONE.
- DONE: `done`=1 and `A`=acc is held stable.
  - `start`=1 reloads operands exactly as in IDLE; `done` drops on that edge.
  - `start`=0 stays in DONE.
- `start` during CALC is ignored. No queueing; the in-flight operation is unaffected.
- Operands are latched at the start edge. Input changes during CALC do not affect the result.
- Arithmetic is unsigned only. All additions are AW bits wide and carry-free by construction.
- Early termination when mplier = 0 is not allowed; latency is fixed.
- `A` outside DONE: shows the internal accumulator and is not guaranteed meaningful. Consumers qualify with `done`.

## Timing
- Reset (`rst`=1 at a rising edge):
  - state = IDLE
  - acc = 0, so `A` = 0
  - `done` = 0, `busy` = 0
  - mcand, mplier, cnt = 0
- Reset dominates `start` on the same edge.
- Reset mid-CALC aborts the operation; the next result requires a fresh start.
- Latency: with `start` sampled at edge k, `busy`=1 after edges k..k+6 and `done`=1 after edge k+7. That is 7 iteration cycles; the result is visible 7 cycles after the start edge.
- Back-to-back operation: `start` held high in DONE restarts every 8 cycles. Throughput is one result per W+1 cycles.
- `busy` and `done` are never high together. Both are registered, with no combinational path from inputs.

## Structure
- Shared package `arit_pkg`, shared with the divider: `W` constant, `AW` constant, `state_t` enum (IDLE, CALC, DONE).
- One combinational sub-module, `paso_shift_add`:
  - inputs: acc, mcand, mplier
  - outputs: next acc, mcand, mplier
- The FSM and registers stay in the top module.

## Test plan
- Q=3, B=2, R=1 → A=7, `done` 7 cycles after the start edge, `busy` high for exactly 7 cycles.
- Divider round-trip vectors:
  - Q=3, B=7, R=1 → A=22
  - Q=7, B=7, R=1 → A=50
  - Q=9, B=13, R=10 → A=127
  - Q=19, B=5, R=4 → A=99
- Extremes:
  - Q=127, B=127, R=127 → A=16256
  - Q=0, B=0, R=5 → A=5
  - Q=0, B=127, R=0 → A=0
  - each with fixed 7-cycle latency.
- `start` pulsed again at CALC cycle 3 with Q=1, B=1, R=0, during a Q=10, B=10, R=3 run → A=103. The second request is ignored and `done` stays 0 afterwards.
- `rst` asserted in CALC cycle 4 → next cycle `A`=0, `done`=0, `busy`=0, state IDLE. A subsequent Q=2, B=3, R=1 → A=7.
- `start` held high continuously from DONE with changing operands → a new result every 8 cycles, and `done` low for exactly 7 cycles between results.
